// File: rtl/pipemem_pkg.sv
// Shared constants, clear-FSM state type and sizing helpers for the pipemem RAM.
package pipemem_pkg;

    localparam int RDLAT_MIN = 1;
    localparam int RDLAT_MAX = 2;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    function automatic int lanes(input int width, input int lane);
        return width / lane;
    endfunction

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipemem_if.sv
// Write/read request bus and status returned by the pipemem RAM.
interface pipemem_if
    import pipemem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512,
    parameter int LANE  = 8
);
    localparam int AW    = addr_bits(DEPTH);
    localparam int LANES = lanes(WIDTH, LANE);

    logic [WIDTH-1:0] data;
    logic [AW-1:0]    wraddress;
    logic             wren;
    logic [LANES-1:0] wrmask;
    logic [AW-1:0]    rdaddress;
    logic             rden;
    logic [WIDTH-1:0] q;
    logic             qvalid;
    logic             busy;

    modport master (
        output data, wraddress, wren, wrmask, rdaddress, rden,
        input  q, qvalid, busy
    );

    modport slave (
        input  data, wraddress, wren, wrmask, rdaddress, rden,
        output q, qvalid, busy
    );
endinterface

// File: rtl/pipemem_clear.sv
// Post-reset clear sequencer: walks every address once, writing zero, while busy is high.
module pipemem_clear
    import pipemem_pkg::*;
#(
    parameter int  DEPTH  = 512,
    parameter bit  ENABLE = 1'b1,
    localparam int AW     = addr_bits(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          busy_o,
    output logic          clr_wren_o,
    output logic [AW-1:0] clr_addr_o
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= ENABLE ? CLR_CLEAR : CLR_IDLE;
            cnt_q   <= '0;
            busy_q  <= ENABLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == CLR_CLEAR);
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_wren_o = 1'b0;
        case (state_q)
            CLR_CLEAR: begin
                clr_wren_o = !reset;
                cnt_d      = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = CLR_IDLE;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign clr_addr_o = cnt_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/pipemem.sv
// Simple dual-port RAM with lane write mask, 1/2-cycle read latency, optional
// write-to-read forwarding and a post-reset zeroing sequence.
module pipemem
    import pipemem_pkg::*;
#(
    parameter int    WIDTH          = 8,
    parameter int    DEPTH          = 512,
    parameter int    LANE           = 8,
    parameter int    RDLAT          = 1,
    parameter bit    BYPASS         = 1'b1,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string FILE           = "",
    parameter string STYLE          = "block"
) (
    input logic       clock,
    input logic       reset,
    pipemem_if.slave  bus
);
    localparam int             LANES    = lanes(WIDTH, LANE);
    localparam int             AW       = addr_bits(DEPTH);
    localparam logic [AW:0]    DEPTH_W  = (AW + 1)'(DEPTH);
    // A non-empty FILE means the contents come from an init image, so zeroing would destroy it.
    localparam bit             DO_CLEAR = CLEAR_ON_RESET && (FILE == "");

    if (RDLAT < RDLAT_MIN || RDLAT > RDLAT_MAX) begin : g_bad_rdlat
        $error("pipemem: RDLAT must be 1 or 2");
    end
    if (WIDTH % LANE != 0) begin : g_bad_lane
        $error("pipemem: WIDTH must be a multiple of LANE");
    end
    if (STYLE != "block" && STYLE != "distributed") begin : g_bad_style
        $error("pipemem: STYLE must be block or distributed");
    end

    logic          busy, clr_wren;
    logic [AW-1:0] clr_addr;

    pipemem_clear #(.DEPTH(DEPTH), .ENABLE(DO_CLEAR)) u_clear (
        .clock      (clock),
        .reset      (reset),
        .busy_o     (busy),
        .clr_wren_o (clr_wren),
        .clr_addr_o (clr_addr)
    );

    (* ram_style = STYLE *) logic [WIDTH-1:0] mem [DEPTH];

    logic             usr_wr, usr_rd, rd_in_range;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data, rd_data_d;
    logic [LANES-1:0] wr_mask;
    logic [WIDTH-1:0] q_q;
    logic             qvalid_q;

    assign rd_in_range = ({1'b0, bus.rdaddress} < DEPTH_W);
    assign usr_wr = bus.wren && (|bus.wrmask) && ({1'b0, bus.wraddress} < DEPTH_W) && !busy && !reset;
    assign usr_rd = bus.rden && !busy && !reset;

    always_comb begin
        wr_en   = usr_wr;
        wr_addr = bus.wraddress;
        wr_data = bus.data;
        wr_mask = bus.wrmask;
        if (clr_wren) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
            wr_mask = '1;
        end
    end

    // NOTE: the array has no reset; known contents come from the clear sequencer instead.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) mem[wr_addr][i*LANE +: LANE] <= wr_data[i*LANE +: LANE];
            end
        end
    end

    // Read-first word, optionally overlaid with lanes written on the same edge.
    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) rd_data_d = mem[bus.rdaddress];
        if (BYPASS && usr_wr && (bus.wraddress == bus.rdaddress)) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wrmask[i]) rd_data_d[i*LANE +: LANE] = bus.data[i*LANE +: LANE];
            end
        end
    end

    if (RDLAT == 1) begin : g_lat1
        always_ff @(posedge clock) begin
            if (reset) begin
                q_q      <= '0;
                qvalid_q <= 1'b0;
            end else begin
                qvalid_q <= usr_rd;
                if (usr_rd) q_q <= rd_data_d;
            end
        end
    end else begin : g_lat2
        logic [WIDTH-1:0] s1_q;
        logic             s1_valid_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                s1_q       <= '0;
                s1_valid_q <= 1'b0;
                q_q        <= '0;
                qvalid_q   <= 1'b0;
            end else begin
                s1_valid_q <= usr_rd;
                if (usr_rd) s1_q <= rd_data_d;
                qvalid_q <= s1_valid_q;
                if (s1_valid_q) q_q <= s1_q;
            end
        end
    end

    assign bus.q      = q_q;
    assign bus.qvalid = qvalid_q;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_pipemem.sv
// Drives two pipemem instances (DEPTH 12/RDLAT 1/BYPASS 1 and DEPTH 16/RDLAT 2/BYPASS 0)
// with identical stimulus and compares every cycle against a word-level reference model.
module tb_pipemem;

    localparam int W  = 32;
    localparam int L  = 8;
    localparam int DA = 12;
    localparam int DB = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipemem_if #(.WIDTH(W), .DEPTH(DA), .LANE(L)) if_a ();
    pipemem_if #(.WIDTH(W), .DEPTH(DB), .LANE(L)) if_b ();

    pipemem #(.WIDTH(W), .DEPTH(DA), .LANE(L), .RDLAT(1), .BYPASS(1'b1),
              .CLEAR_ON_RESET(1'b1)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
    pipemem #(.WIDTH(W), .DEPTH(DB), .LANE(L), .RDLAT(2), .BYPASS(1'b0),
              .CLEAR_ON_RESET(1'b1)) dut_b (.clock(clock), .reset(reset), .bus(if_b));

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    // current request
    logic        we_v, re_v;
    logic [3:0]  wa_v, ra_v, wm_v;
    logic [31:0] d_v;

    // reference model: word arrays, remaining clear words, results scheduled by due cycle
    logic [31:0] mem_m  [2][16];
    int          clr_left [2];
    logic        slot_v [2][4];
    logic [31:0] slot_q [2][4];
    logic        exp_v  [2];
    logic [31:0] exp_q  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] wm,
                         input logic [31:0] d, input logic re, input logic [3:0] ra);
        we_v = we; wa_v = wa; wm_v = wm; d_v = d; re_v = re; ra_v = ra;
        if_a.wren = we; if_a.wraddress = wa; if_a.wrmask = wm; if_a.data = d;
        if_a.rden = re; if_a.rdaddress = ra;
        if_b.wren = we; if_b.wraddress = wa; if_b.wrmask = wm; if_b.data = d;
        if_b.rden = re; if_b.rdaddress = ra;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
    endtask

    task automatic model_edge(input int k);
        int          dep;
        int          lat;
        logic [31:0] val;
        dep = (k == 0) ? DA : DB;
        lat = (k == 0) ? 1 : 2;
        if (reset) begin
            clr_left[k] = dep;
            for (int s = 0; s < 4; s++) slot_v[k][s] = 1'b0;
            exp_v[k] = 1'b0;
            exp_q[k] = 32'd0;
            return;
        end
        if (clr_left[k] > 0) begin
            mem_m[k][dep - clr_left[k]] = 32'd0;
            clr_left[k]--;
        end else begin
            if (re_v) begin
                val = (int'(ra_v) < dep) ? mem_m[k][ra_v] : 32'd0;
                if (k == 0 && we_v && wa_v == ra_v && int'(wa_v) < dep)
                    for (int i = 0; i < 4; i++) if (wm_v[i]) val[8*i +: 8] = d_v[8*i +: 8];
                slot_v[k][(cyc + lat - 1) % 4] = 1'b1;
                slot_q[k][(cyc + lat - 1) % 4] = val;
            end
            if (we_v && int'(wa_v) < dep)
                for (int i = 0; i < 4; i++) if (wm_v[i]) mem_m[k][wa_v][8*i +: 8] = d_v[8*i +: 8];
        end
        if (slot_v[k][cyc % 4]) begin
            exp_v[k] = 1'b1;
            exp_q[k] = slot_q[k][cyc % 4];
            slot_v[k][cyc % 4] = 1'b0;
        end else begin
            exp_v[k] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        for (int k = 0; k < 2; k++) model_edge(k);
        if (reset) armed = 1'b1;
        @(negedge clock);
        if (armed) begin
            check("a_busy",   {31'd0, if_a.busy},   {31'd0, clr_left[0] > 0});
            check("b_busy",   {31'd0, if_b.busy},   {31'd0, clr_left[1] > 0});
            check("a_qvalid", {31'd0, if_a.qvalid}, {31'd0, exp_v[0]});
            check("b_qvalid", {31'd0, if_b.qvalid}, {31'd0, exp_v[1]});
            check("a_q", if_a.q, exp_q[0]);
            check("b_q", if_b.q, exp_q[1]);
        end
    endtask

    task automatic write(input logic [3:0] wa, input logic [31:0] d, input logic [3:0] wm);
        drive(1'b1, wa, wm, d, 1'b0, 4'd0);
        step();
        idle();
    endtask

    // One read; checks the RDLAT=1 result after the first edge and the RDLAT=2 result after the second.
    task automatic read_chk(input logic [3:0] ra, input logic [31:0] exp_a,
                            input logic [31:0] exp_b, input string tag);
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, ra);
        step();
        idle();
        check({"a_", tag},       if_a.q, exp_a);
        check({"a_lat_", tag},   {31'd0, if_a.qvalid}, 32'd1);
        check({"b_early_", tag}, {31'd0, if_b.qvalid}, 32'd0);
        step();
        check({"b_", tag},       if_b.q, exp_b);
        check({"b_lat_", tag},   {31'd0, if_b.qvalid}, 32'd1);
        check({"a_once_", tag},  {31'd0, if_a.qvalid}, 32'd0);
    endtask

    // Counts busy-high cycles from reset release; requests stay asserted while both are busy.
    task automatic busy_run(input bit with_reqs, output int cnt_a, output int cnt_b);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            if (if_a.busy) cnt_a++;
            if (if_b.busy) cnt_b++;
            if (!if_a.busy && !if_b.busy) break;
            if (with_reqs && if_a.busy) drive(1'b1, 4'd3, 4'hF, 32'h5A5A5A5A, 1'b1, 4'd3);
            else idle();
            step();
        end
        idle();
    endtask

    initial begin
        int ca, cb;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 16; a++) mem_m[k][a] = 32'd0;
            for (int s = 0; s < 4; s++) slot_v[k][s] = 1'b0;
            clr_left[k] = 0;
            exp_v[k] = 1'b0;
            exp_q[k] = 32'd0;
        end
        idle();
        reset = 1'b1;

        // clear after reset, with dropped requests during busy
        repeat (3) step();
        reset = 1'b0;
        busy_run(1'b1, ca, cb);
        check("a_busy_len", ca, DA);
        check("b_busy_len", cb, DB);
        for (int a = 0; a < 16; a++) read_chk(4'(a), 32'd0, 32'd0, "clr");

        // lane-masked write
        write(4'd5, 32'hAABBCCDD, 4'hF);
        write(4'd5, 32'h11223344, 4'h5);
        read_chk(4'd5, 32'hAA22CC44, 32'hAA22CC44, "mask");

        // same-edge write and read of one address
        write(4'd7, 32'h00000000, 4'hF);
        drive(1'b1, 4'd7, 4'h3, 32'hFFFFFFFF, 1'b1, 4'd7);
        step();
        idle();
        check("a_fwd", if_a.q, 32'h0000FFFF);
        step();
        check("b_fwd", if_b.q, 32'h00000000);
        read_chk(4'd7, 32'h0000FFFF, 32'h0000FFFF, "fwd_after");

        // streaming reads with no bubbles
        for (int a = 0; a < 8; a++) write(4'(a), 32'(10 * a), 4'hF);
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
            step();
            check("a_stream", if_a.q, 32'(10 * a));
            if (a > 0) begin
                check("b_stream", if_b.q, 32'(10 * (a - 1)));
                check("b_stream_v", {31'd0, if_b.qvalid}, 32'd1);
            end
        end
        idle();
        step();
        check("b_stream", if_b.q, 32'd70);
        check("b_stream_v", {31'd0, if_b.qvalid}, 32'd1);

        // reset reasserted part-way through the clear
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(i));
            step();
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        busy_run(1'b1, ca, cb);
        check("a_busy_len2", ca, DA);
        check("b_busy_len2", cb, DB);
        read_chk(4'd5, 32'd0, 32'd0, "recleared");

        // address boundary for the 12-word instance
        write(4'd11, 32'h12345678, 4'hF);
        write(4'd13, 32'hDEADBEEF, 4'hF);
        read_chk(4'd15, 32'd0, 32'd0, "oob15");
        read_chk(4'd13, 32'd0, 32'hDEADBEEF, "oob13");
        read_chk(4'd11, 32'h12345678, 32'h12345678, "last");
        read_chk(4'd1, 32'd0, 32'd0, "noalias");

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic [3:0] wa, ra;
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom(),
                  ($urandom_range(0, 9) < 6), ra);
            step();
        end
        reset = 1'b0;
        idle();
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
